ex_muldiv: RTL and testbench

//  Iterative HI/LO multiply/divide unit of the EX stage, fed by ID operand outputs data_1 (rs) / data_2 (rt).

---
 rtl/ex_muldiv.sv | 191 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// One shift-add (mult) or restoring shift-subtract (div) step per clock, then a sign-fix cycle.
module ex_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: running high product half / partial remainder
    logic [WIDTH-1:0] acc_q, acc_d;
    // q: multiplier being shifted out / dividend shifted out, quotient shifted in
    logic [WIDTH-1:0] q_q, q_d;
    // b: multiplicand / divisor magnitude
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             div0_q, div0_d;

    logic             op_signed;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_abs;
    logic [WIDTH-1:0] rt_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod;

    // Operand conditioning and single datapath step, shared by mult and div
    always_comb begin
        op_signed = ~op[0];
        rs_neg    = op_signed & rs_data[WIDTH-1];
        rt_neg    = op_signed & rt_data[WIDTH-1];
        rs_abs    = rs_neg ? -rs_data : rs_data;
        rt_abs    = rt_neg ? -rt_data : rt_data;
        mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_q, q_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        prod      = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
    end

    // Next-state logic for FSM, HI/LO and datapath registers
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        b_d       = b_q;
        rs_d      = rs_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        unique case (state_q)
            StIdle: begin
                // flush squashes anything issued in the same cycle
                if (start && !flush) begin
                    if (!op[2]) begin
                        state_d   = StRun;
                        busy_d    = 1'b1;
                        cnt_d     = '0;
                        acc_d     = '0;
                        is_div_d  = op[1];
                        neg_d     = rs_neg ^ rt_neg;
                        rem_neg_d = rs_neg;
                        div0_d    = (rt_data == '0);
                        rs_d      = rs_data;
                        b_d       = op[1] ? rt_abs : rs_abs;
                        q_d       = op[1] ? rs_abs : rt_abs;
                    end else if (!op[1]) begin
                        if (op[0]) begin
                            lo_d = rs_data;
                        end else begin
                            hi_d = rs_data;
                        end
                    end
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[WIDTH]) begin
                            acc_d = div_diff[WIDTH-1:0];
                            q_d   = {q_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = div_shift[WIDTH-1:0];
                            q_d   = {q_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (div0_q) begin
                        hi_d = rs_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_neg_q ? -acc_q : acc_q;
                        lo_d = neg_q ? -q_q : q_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            b_q       <= '0;
            rs_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            b_q       <= b_d;
            rs_q      <= rs_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;
    localparam logic [2:0] OpNop   = 3'b110;

    ex_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .flush   (flush),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        tick();
        start   = 1'b0;
        op      = OpNop;
    endtask

    // Waits (bounded) for done after an issue; start edge is E0, done expected after E33
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
        check({tag, " latency"}, n, 33);
    endtask

    initial begin
        logic ok;
        rst     = 1'b1;
        start   = 1'b0;
        op      = OpNop;
        flush   = 1'b0;
        rs_data = '0;
        rt_data = '0;
        tick();
        tick();
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        tick();

        // MULTU max*max with cycle-exact busy window
        issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu busy E0", {31'b0, busy}, 32'h1);
        ok = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (!busy || done || hi !== 32'h0 || lo !== 32'h0) ok = 1'b0;
        end
        check("multu busy/hold E1..E32", {31'b0, ok}, 32'h1);
        tick();
        check("multu done E33", {31'b0, done}, 32'h1);
        check("multu busy E33", {31'b0, busy}, 32'h0);
        check("multu hi", hi, 32'hFFFF_FFFE);
        check("multu lo", lo, 32'h0000_0001);
        tick();
        check("multu done pulse", {31'b0, done}, 32'h0);

        // MULT -3*5, then DIV -7/2 issued in the done cycle
        issue(OpMult, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult");
        check("mult hi", hi, 32'hFFFF_FFFF);
        check("mult lo", lo, 32'hFFFF_FFF1);
        issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
        check("div accepted in done cycle", {31'b0, busy}, 32'h1);
        wait_done("div");
        check("div lo", lo, 32'hFFFF_FFFD);
        check("div hi", hi, 32'hFFFF_FFFF);

        // Divide by zero and signed overflow
        issue(OpDivu, 32'd100, 32'd0);
        wait_done("divu0");
        check("divu0 lo", lo, 32'hFFFF_FFFF);
        check("divu0 hi", hi, 32'd100);
        issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("divovf");
        check("divovf lo", lo, 32'h8000_0000);
        check("divovf hi", hi, 32'h0);

        // MTHI / MTLO
        issue(OpMthi, 32'h1234_5678, 32'h0);
        check("mthi hi", hi, 32'h1234_5678);
        check("mthi lo", lo, 32'h8000_0000);
        check("mthi busy", {31'b0, busy}, 32'h0);
        check("mthi done", {31'b0, done}, 32'h0);
        issue(OpMtlo, 32'hCAFE_BABE, 32'h0);
        check("mtlo lo", lo, 32'hCAFE_BABE);
        check("mtlo hi", hi, 32'h1234_5678);
        check("mtlo busy", {31'b0, busy}, 32'h0);
        check("mtlo done", {31'b0, done}, 32'h0);

        // Flush and start together in IDLE: op squashed
        flush = 1'b1;
        issue(OpMthi, 32'hAAAA_5555, 32'h0);
        flush = 1'b0;
        check("flush+mthi hi", hi, 32'h1234_5678);

        // MULT in flight: MTLO ignored at step 5, flush at step 10
        issue(OpMult, 32'd3, 32'd4);
        repeat (4) tick();
        issue(OpMtlo, 32'hDEAD_BEEF, 32'h0);
        check("mtlo while busy lo", lo, 32'hCAFE_BABE);
        check("mtlo while busy busy", {31'b0, busy}, 32'h1);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'h0);
        check("flush done", {31'b0, done}, 32'h0);
        check("flush hi", hi, 32'h1234_5678);
        check("flush lo", lo, 32'hCAFE_BABE);
        ok = 1'b1;
        repeat (40) begin
            tick();
            if (done || busy) ok = 1'b0;
        end
        check("flush no late done", {31'b0, ok}, 32'h1);

        // Async reset mid-DIVU
        issue(OpDivu, 32'd1000, 32'd7);
        repeat (12) tick();
        #2 rst = 1'b1;
        #1;
        check("async rst hi", hi, 32'h0);
        check("async rst lo", lo, 32'h0);
        check("async rst busy", {31'b0, busy}, 32'h0);
        #1 rst = 1'b0;
        tick();
        issue(OpMultu, 32'd6, 32'd7);
        wait_done("multu 6*7");
        check("multu 6*7 lo", lo, 32'd42);
        check("multu 6*7 hi", hi, 32'h0);

        // Flush in the FIX cycle: no write, no done
        issue(OpMultu, 32'd2, 32'd3);
        repeat (32) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fix flush done", {31'b0, done}, 32'h0);
        check("fix flush busy", {31'b0, busy}, 32'h0);
        check("fix flush lo", lo, 32'd42);
        tick();
        check("fix flush done later", {31'b0, done}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
